// File: rtl/rf_wb_sched_pkg.sv
// Shared constants for the integer register-file write-back path.
package rf_wb_sched_pkg;
  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;
  localparam int REG_COUNT = 32;
  localparam int N_REQ     = 3;
  localparam int REQ_IDXW  = $clog2(N_REQ);

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;
endpackage

// File: rtl/rf_wb_sched_if.sv
// Write-back requester, issue-stage and register-file write signals.
import rf_wb_sched_pkg::*;

interface rf_wb_sched_if;
  logic [N_REQ-1:0]           i_req_valid;
  logic [N_REQ*REG_ADDRW-1:0] i_req_rd;
  logic [N_REQ*CPU_WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]           o_req_ready;

  logic                 i_iss_valid;
  logic [REG_ADDRW-1:0] i_iss_rd;
  logic [REG_ADDRW-1:0] i_rs1;
  logic [REG_ADDRW-1:0] i_rs2;
  logic                 o_rs1_busy;
  logic                 o_rs2_busy;
  logic                 o_rd_busy;
  logic                 i_flush;

  logic                 o_wen;
  logic [REG_ADDRW-1:0] o_waddr;
  logic [CPU_WIDTH-1:0] o_wdata;

  modport slave (
    input  i_req_valid, i_req_rd, i_req_data, i_iss_valid, i_iss_rd,
           i_rs1, i_rs2, i_flush,
    output o_req_ready, o_rs1_busy, o_rs2_busy, o_rd_busy,
           o_wen, o_waddr, o_wdata
  );

  modport master (
    output i_req_valid, i_req_rd, i_req_data, i_iss_valid, i_iss_rd,
           i_rs1, i_rs2, i_flush,
    input  o_req_ready, o_rs1_busy, o_rs2_busy, o_rd_busy,
           o_wen, o_waddr, o_wdata
  );
endinterface

// File: rtl/rf_wb_sched_rr_arb.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module rf_wb_sched_rr_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  always_comb begin
    logic found;
    int   pos;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int off = 1; off <= N; off++) begin
      pos = int'(last_i) + off;
      if (pos >= N) pos = pos - N;
      if (!found && valid_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        grant_idx_o  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler: shares the register-file write port among requesters
// and keeps the per-register pending-write scoreboard for the issue stage.
import rf_wb_sched_pkg::*;

module rf_wb_sched (
  input  logic         i_clk,
  input  logic         i_rst,
  rf_wb_sched_if.slave bus
);

  logic [N_REQ-1:0]     grant;
  logic [REQ_IDXW-1:0]  grant_idx;
  logic [N_REQ-1:0]     ready;
  logic                 xfer;
  logic [REG_ADDRW-1:0] sel_rd;
  logic [CPU_WIDTH-1:0] sel_data;

  logic [REQ_IDXW-1:0]  last_q, last_d;
  logic                 wen_q, wen_d;
  logic [REG_ADDRW-1:0] waddr_q, waddr_d;
  logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
  logic [REG_COUNT-1:0] busy_q, busy_d;

  rf_wb_sched_rr_arb #(.N(N_REQ), .IW(REQ_IDXW)) u_arb (
    .valid_i     (bus.i_req_valid),
    .last_i      (last_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign ready           = i_rst ? '0 : grant;
  assign xfer            = |ready;
  assign bus.o_req_ready = ready;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_rd   = bus.i_req_rd[k*REG_ADDRW +: REG_ADDRW];
        sel_data = bus.i_req_data[k*CPU_WIDTH +: CPU_WIDTH];
      end
    end
  end

  // Address and data hold when idle; only the enable drops.
  always_comb begin
    last_d  = last_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      last_d  = grant_idx;
      wen_d   = (sel_rd != '0);
      waddr_d = sel_rd;
      wdata_d = sel_data;
    end
  end

  // Clear then set so a same-cycle issue to the written register wins; flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (bus.i_iss_valid && (bus.i_iss_rd != '0)) busy_d[bus.i_iss_rd] = 1'b1;
    if (bus.i_flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q  <= REQ_IDXW'(N_REQ - 1);
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_rs1_busy = busy_q[bus.i_rs1];
  assign bus.o_rs2_busy = busy_q[bus.i_rs2];
  assign bus.o_rd_busy  = busy_q[bus.i_iss_rd];
  assign bus.o_wen      = wen_q;
  assign bus.o_waddr    = waddr_q;
  assign bus.o_wdata    = wdata_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched.
import rf_wb_sched_pkg::*;

module tb_rf_wb_sched;
  logic i_clk = 1'b0;
  logic i_rst;
  int   nchk = 0;
  int   nerr = 0;

  rf_wb_sched_if bus ();

  rf_wb_sched dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge i_clk);
  endtask

  task automatic set_req(input int k, input logic v, input logic [4:0] rd, input logic [63:0] d);
    bus.i_req_valid[k]              = v;
    bus.i_req_rd[k*REG_ADDRW +: 5]  = rd;
    bus.i_req_data[k*CPU_WIDTH +: 64] = d;
  endtask

  initial begin
    i_rst           = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_rd    = '0;
    bus.i_req_data  = '0;
    bus.i_iss_valid = 1'b0;
    bus.i_iss_rd    = '0;
    bus.i_rs1       = 5'd5;
    bus.i_rs2       = 5'd7;
    bus.i_flush     = 1'b0;

    // reset for two cycles; requesters valid must not see ready
    cyc();
    bus.i_req_valid = 3'b111;
    settle();
    chk("rst_ready", bus.o_req_ready, 3'b000);
    chk("rst_wen", bus.o_wen, 1'b0);
    cyc();
    i_rst           = 1'b0;
    bus.i_req_valid = '0;

    // idle
    settle();
    chk("idle_wen", bus.o_wen, 1'b0);
    chk("idle_waddr", bus.o_waddr, 5'd0);
    chk("idle_wdata", bus.o_wdata, 64'd0);
    chk("idle_ready", bus.o_req_ready, 3'b000);
    chk("idle_rs1", bus.o_rs1_busy, 1'b0);
    chk("idle_rs2", bus.o_rs2_busy, 1'b0);
    cyc();

    // single write: issue rd=5
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rd    = 5'd5;
    settle();
    chk("sw_nobypass", bus.o_rs1_busy, 1'b0);
    cyc();
    bus.i_iss_valid = 1'b0;
    settle();
    chk("sw_rs1_set", bus.o_rs1_busy, 1'b1);
    chk("sw_rd_busy", bus.o_rd_busy, 1'b1);
    cyc();
    set_req(REQ_ALU, 1'b1, 5'd5, 64'hDEAD);
    settle();
    chk("sw_ready", bus.o_req_ready, 3'b001);
    chk("sw_rs1_grant", bus.o_rs1_busy, 1'b1);
    cyc();
    set_req(REQ_ALU, 1'b0, 5'd0, 64'd0);
    settle();
    chk("sw_wen", bus.o_wen, 1'b1);
    chk("sw_waddr", bus.o_waddr, 5'd5);
    chk("sw_wdata", bus.o_wdata, 64'hDEAD);
    chk("sw_rs1_t1", bus.o_rs1_busy, 1'b1);
    cyc();
    settle();
    chk("sw_wen_drop", bus.o_wen, 1'b0);
    chk("sw_waddr_hold", bus.o_waddr, 5'd5);
    chk("sw_wdata_hold", bus.o_wdata, 64'hDEAD);
    chk("sw_rs1_clr", bus.o_rs1_busy, 1'b0);
    cyc();

    // LSU write then reset while it is in flight (last=0, so LSU searched first)
    set_req(REQ_LSU, 1'b1, 5'd9, 64'h99);
    set_req(REQ_MDU, 1'b1, 5'd10, 64'hAA);
    settle();
    chk("mid_ready", bus.o_req_ready, 3'b010);
    cyc();
    set_req(REQ_LSU, 1'b0, 5'd0, 64'd0);
    set_req(REQ_MDU, 1'b0, 5'd0, 64'd0);
    i_rst = 1'b1;
    settle();
    chk("mid_wen_before", bus.o_wen, 1'b1);
    chk("mid_waddr_before", bus.o_waddr, 5'd9);
    cyc();
    i_rst = 1'b0;
    settle();
    chk("mid_wen_dropped", bus.o_wen, 1'b0);
    chk("mid_waddr_rst", bus.o_waddr, 5'd0);
    cyc();

    // round robin with all three valid
    set_req(REQ_ALU, 1'b1, 5'd1, 64'h11);
    set_req(REQ_LSU, 1'b1, 5'd2, 64'h22);
    set_req(REQ_MDU, 1'b1, 5'd3, 64'h33);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("rr_ready%0d", i), bus.o_req_ready, 3'b001 << (i % 3));
      if (i > 0) begin
        chk($sformatf("rr_wen%0d", i), bus.o_wen, 1'b1);
        chk($sformatf("rr_waddr%0d", i), bus.o_waddr, 5'((i - 1) % 3 + 1));
      end
      cyc();
    end
    bus.i_req_valid = '0;
    settle();
    chk("rr_last_waddr", bus.o_waddr, 5'd3);
    chk("rr_last_wdata", bus.o_wdata, 64'h33);
    cyc();

    // set/clear collision on rd=7 (last=2, ALU searched first)
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rd    = 5'd7;
    cyc();
    bus.i_iss_valid = 1'b0;
    set_req(REQ_ALU, 1'b1, 5'd7, 64'h77);
    settle();
    chk("col_ready", bus.o_req_ready, 3'b001);
    cyc();
    set_req(REQ_ALU, 1'b0, 5'd0, 64'd0);
    bus.i_iss_valid = 1'b1;
    settle();
    chk("col_wen", bus.o_wen, 1'b1);
    chk("col_waddr", bus.o_waddr, 5'd7);
    chk("col_rd_busy", bus.o_rd_busy, 1'b1);
    cyc();
    bus.i_iss_valid = 1'b0;
    settle();
    chk("col_set_wins", bus.o_rs2_busy, 1'b1);
    cyc();

    // x0: issue rd=0 and LSU write to x0 (last=0)
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rd    = 5'd0;
    bus.i_rs1       = 5'd0;
    set_req(REQ_LSU, 1'b1, 5'd0, 64'h55);
    settle();
    chk("x0_ready", bus.o_req_ready, 3'b010);
    cyc();
    bus.i_iss_valid = 1'b0;
    set_req(REQ_LSU, 1'b0, 5'd0, 64'd0);
    settle();
    chk("x0_wen", bus.o_wen, 1'b0);
    chk("x0_waddr", bus.o_waddr, 5'd0);
    chk("x0_wdata", bus.o_wdata, 64'h55);
    chk("x0_busy", bus.o_rs1_busy, 1'b0);
    chk("x0_rd_busy", bus.o_rd_busy, 1'b0);
    chk("x0_r7_still", bus.o_rs2_busy, 1'b1);
    cyc();

    // flush with MDU write to rd=3 in flight (last=1, MDU searched first)
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rd    = 5'd3;
    cyc();
    bus.i_iss_rd = 5'd4;
    cyc();
    bus.i_iss_rd = 5'd9;
    bus.i_rs1    = 5'd3;
    bus.i_rs2    = 5'd4;
    bus.i_flush  = 1'b1;
    set_req(REQ_MDU, 1'b1, 5'd3, 64'h333);
    settle();
    chk("fl_rs1_pre", bus.o_rs1_busy, 1'b1);
    chk("fl_rs2_pre", bus.o_rs2_busy, 1'b1);
    chk("fl_ready", bus.o_req_ready, 3'b100);
    cyc();
    bus.i_iss_valid = 1'b0;
    bus.i_flush     = 1'b0;
    set_req(REQ_MDU, 1'b0, 5'd0, 64'd0);
    settle();
    chk("fl_rs1_clr", bus.o_rs1_busy, 1'b0);
    chk("fl_rs2_clr", bus.o_rs2_busy, 1'b0);
    chk("fl_iss_overridden", bus.o_rd_busy, 1'b0);
    chk("fl_wen", bus.o_wen, 1'b1);
    chk("fl_waddr", bus.o_waddr, 5'd3);
    chk("fl_wdata", bus.o_wdata, 64'h333);
    bus.i_rs1 = 5'd7;
    #1;
    chk("fl_r7_clr", bus.o_rs1_busy, 1'b0);
    cyc();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
